// File: rtl/aukv_uart_rx.sv
// aukv_uart_rx: UART 8N1 receiver.
// A 2-flop synchroniser feeds a mid-bit sampling FSM. Each received byte is
// placed in a one-entry holding register and presented on a valid/ready
// interface. A bad stop bit produces a frame-error pulse. A byte that arrives
// while the holding register is still full produces an overrun pulse.
module aukv_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  // The start bit is confirmed half a bit time after its falling edge, so
  // every later sample falls in the middle of its bit.
  localparam logic [CW-1:0] H_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic          deliver, load;

  // Two-flop synchroniser. It resets to the idle (high) line level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic for the receive FSM, bit counter and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == H_LAST) begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;  // the low level was a glitch, not a start bit
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == C_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = sync2_q;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == C_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // Wait for the line to return high, so a held-low line (break)
        // does not start a new frame over and over.
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register. A byte is loaded when the slot is empty or is being
  // emptied in the same cycle. Otherwise the new byte is dropped and an
  // overrun is flagged.
  always_comb begin
    load    = deliver & (~valid_q | i_ready);
    ovr_d   = deliver & valid_q & ~i_ready;
    data_d  = load ? shift_q : data_q;
    valid_d = load ? 1'b1 : ((valid_q & i_ready) ? 1'b0 : valid_q);
    busy_d  = (state_d != S_IDLE);
  end

  // Register the FSM, datapath and output flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_aukv_uart_rx.sv
// Bench for aukv_uart_rx with CLKS_PER_BIT=8. Frames are driven on the
// falling clock edge. Outputs are sampled 1 ns after the falling edge.
module tb_aukv_uart_rx;
  localparam int C = 8;
  localparam int H = C / 2;
  // From the falling edge that drives the start bit to the cycle in which
  // the byte is visible: 1 edge to reach sync1, 2 more to enter START,
  // then H cycles for the half bit and 9*C cycles for 8 data bits plus stop.
  localparam int LAT = 1 + 2 + H + 9 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int t0 = 0;

  // Observed events, collected by the monitor below.
  logic [7:0] load_q[$];
  int load_cyc, ferr_n, ferr_cyc, ovr_n, ovr_cyc, vhi_n, both_n;
  logic vprev = 1'b0, aprev = 1'b0;

  aukv_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_data(data), .o_valid(valid),
    .i_ready(rdy), .o_frame_err(ferr), .o_overrun(ovr), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A new byte is visible when o_valid rises, or when o_valid stays high
  // after a handshake in the previous cycle.
  always @(negedge clk) begin
    #1;
    if (valid) vhi_n++;
    if (valid && (!vprev || aprev)) begin
      load_q.push_back(data);
      load_cyc = cyc;
    end
    if (ferr) begin ferr_n++; ferr_cyc = cyc; end
    if (ovr) begin ovr_n++; ovr_cyc = cyc; end
    if (ferr && ovr) both_n++;
    vprev = valid;
    aprev = valid && rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    load_q.delete();
    ferr_n = 0; ovr_n = 0; vhi_n = 0; both_n = 0;
    load_cyc = -1; ferr_cyc = -1; ovr_cyc = -1;
  endtask

  // Call right after a falling edge. Drives the first nbits bits of a frame
  // {stop, byte, start}, each held for C cycles, and records the start cycle in t0.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vectors++;
    if ({data, valid, ferr, ovr, busy} !== 12'h000) begin
      errs++;
      $display("FAIL reset_outputs: got %h, expected 000", {data, valid, ferr, ovr, busy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({valid, busy} !== 2'b00) begin
      errs++;
      $display("FAIL reset_idle: valid,busy got %b, expected 00", {valid, busy});
    end
  endtask

  task automatic test_basic();
    clr(); rdy = 1'b1;
    send_frame(8'h55, 1'b1, 10);
    repeat (4) @(negedge clk);
    vectors++;
    if (load_q.size() != 1 || load_q[0] !== 8'h55) begin
      errs++;
      $display("FAIL basic_data: got %0d loads (first %h), expected 1 load of 55",
               load_q.size(), load_q.size() ? load_q[0] : 8'hxx);
    end
    vectors++;
    if (load_cyc != t0 + LAT) begin
      errs++;
      $display("FAIL basic_latency: got cycle %0d, expected %0d", load_cyc, t0 + LAT);
    end
    vectors++;
    if (vhi_n != 1) begin
      errs++;
      $display("FAIL basic_valid_width: got %0d cycles, expected 1", vhi_n);
    end
    vectors++;
    if (ferr_n != 0 || ovr_n != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_flags: ferr %0d ovr %0d busy %b, expected 0 0 0", ferr_n, ovr_n, busy);
    end
  endtask

  task automatic test_back_to_back();
    int t_second;
    clr(); rdy = 1'b0;
    send_frame(8'hA5, 1'b1, 10);
    send_frame(8'h3C, 1'b1, 10);
    t_second = t0;
    repeat (4) @(negedge clk);
    vectors++;
    if (ovr_n != 1 || ovr_cyc != t_second + LAT) begin
      errs++;
      $display("FAIL overrun_pulse: got %0d pulses at cycle %0d, expected 1 at %0d", ovr_n, ovr_cyc, t_second + LAT);
    end
    vectors++;
    if (valid !== 1'b1 || data !== 8'hA5) begin
      errs++;
      $display("FAIL overrun_hold: valid %b data %h, expected 1 a5", valid, data);
    end
    rdy = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (valid !== 1'b0) begin
      errs++;
      $display("FAIL overrun_drain: valid %b, expected 0", valid);
    end
    vectors++;
    if (load_q.size() != 1 || ferr_n != 0) begin
      errs++;
      $display("FAIL overrun_loads: got %0d loads, ferr %0d, expected 1 load, 0 ferr", load_q.size(), ferr_n);
    end
  endtask

  task automatic test_frame_err();
    int t_bad;
    clr(); rdy = 1'b1;
    send_frame(8'hFF, 1'b0, 10);
    t_bad = t0;
    repeat (3 * C) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL break_busy: busy %b, expected 1", busy);
    end
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL break_release: busy %b, expected 0", busy);
    end
    vectors++;
    if (ferr_n != 1 || ferr_cyc != t_bad + LAT || load_q.size() != 0) begin
      errs++;
      $display("FAIL frame_err: %0d pulses at cycle %0d, %0d loads; expected 1 at %0d, 0 loads",
               ferr_n, ferr_cyc, load_q.size(), t_bad + LAT);
    end
    @(negedge clk);
    send_frame(8'h12, 1'b1, 10);
    repeat (4) @(negedge clk);
    vectors++;
    if (load_q.size() != 1 || load_q[0] !== 8'h12 || ferr_n != 1) begin
      errs++;
      $display("FAIL after_break: got %0d loads (first %h), ferr %0d; expected 1 load of 12, ferr 1",
               load_q.size(), load_q.size() ? load_q[0] : 8'hxx, ferr_n);
    end
  endtask

  task automatic test_glitch();
    clr();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL glitch_busy: busy %b, expected 1", busy);
    end
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL glitch_abort: busy %b, expected 0", busy);
    end
    repeat (2 * C) @(negedge clk);
    vectors++;
    if (load_q.size() != 0 || ferr_n != 0 || ovr_n != 0) begin
      errs++;
      $display("FAIL glitch_quiet: loads %0d ferr %0d ovr %0d, expected 0 0 0", load_q.size(), ferr_n, ovr_n);
    end
  endtask

  task automatic test_reset_mid();
    clr(); rdy = 1'b0;
    send_frame(8'h5A, 1'b1, 10);
    repeat (2) @(negedge clk);
    send_frame(8'hC3, 1'b1, 5);  // start + bits 0..3
    rx = 1'b0;                    // bit 4 of C3
    repeat (H) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, valid, data} !== 10'h000) begin
      errs++;
      $display("FAIL reset_mid: busy,valid,data got %h, expected 000", {busy, valid, data});
    end
    @(negedge clk);
    rst = 1'b0; rx = 1'b1;
    repeat (C) @(negedge clk);
    clr(); rdy = 1'b1;
    send_frame(8'h81, 1'b1, 10);
    repeat (4) @(negedge clk);
    vectors++;
    if (load_q.size() != 1 || load_q[0] !== 8'h81 || data !== 8'h81) begin
      errs++;
      $display("FAIL reset_recover: got %0d loads (first %h), data %h; expected 1 load of 81",
               load_q.size(), load_q.size() ? load_q[0] : 8'hxx, data);
    end
  endtask

  task automatic test_refill();
    clr(); rdy = 1'b0;
    send_frame(8'h11, 1'b1, 10);
    fork
      send_frame(8'h22, 1'b1, 10);
      begin
        repeat (LAT - 1) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (valid !== 1'b1 || data !== 8'h22 || ovr_n != 0) begin
      errs++;
      $display("FAIL refill: valid %b data %h ovr %0d, expected 1 22 0", valid, data, ovr_n);
    end
    vectors++;
    if (load_q.size() != 2 || load_q[1] !== 8'h22) begin
      errs++;
      $display("FAIL refill_loads: got %0d loads, expected 2 (11 then 22)", load_q.size());
    end
    rdy = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int gap;
    rdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 6);
      clr();
      send_frame(b, 1'b1, 10);
      vectors++;
      if (load_q.size() != 1 || load_q[0] !== b || load_cyc != t0 + LAT) begin
        errs++;
        $display("FAIL random_%0d: got %0d loads (first %h) at cycle %0d, expected %h at %0d",
                 n, load_q.size(), load_q.size() ? load_q[0] : 8'hxx, load_cyc, b, t0 + LAT);
      end
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (both_n != 0) begin
      errs++;
      $display("FAIL err_exclusive: %0d cycles had both frame_err and overrun, expected 0", both_n);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
